// File: rtl/cu_pipe_ctrl.sv
// Pipelined control unit: decodes the ID instruction into a 21-bit control word
// and carries it with a valid bit through the EX, MEM and WB stage registers.
module cu_pipe_ctrl #(
    parameter int CNT_W        = 16,
    parameter bit ILLEGAL_TRAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instruction,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [20:0]      id_ctrl,
    output logic [20:0]      ex_ctrl,
    output logic [20:0]      mem_ctrl,
    output logic [20:0]      wb_ctrl,
    output logic             ex_valid,
    output logic             mem_valid,
    output logic             wb_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    logic [5:0] opcode;
    logic [5:0] op2;
    logic [1:0] srd;
    logic [1:0] psw_le_re;
    logic       b;
    logic [2:0] soh_op;
    logic [3:0] alu_op;
    logic [3:0] ram_ctrl;
    logic       l;
    logic       rf_le;
    logic [1:0] id_sr;
    logic       ub;
    logic       legal;
    logic       accept;
    logic       ex_load;

    assign opcode = instruction[31:26];
    assign op2    = instruction[11:6];

    // Field-level decode; an illegal encoding leaves every field at zero.
    always_comb begin
        srd       = 2'b00;
        psw_le_re = 2'b00;
        b         = 1'b0;
        soh_op    = 3'b000;
        alu_op    = 4'b0000;
        ram_ctrl  = 4'b0000;
        l         = 1'b0;
        rf_le     = 1'b0;
        id_sr     = 2'b00;
        ub        = 1'b0;
        legal     = 1'b1;
        case (opcode)
            6'b000000: ;
            6'b000010: begin
                rf_le = 1'b1;
                case (op2)
                    6'b011000: alu_op = 4'b0000;
                    6'b011100: alu_op = 4'b0001;
                    6'b010000: alu_op = 4'b0010;
                    6'b001001: alu_op = 4'b0110;
                    default: begin
                        rf_le = 1'b0;
                        legal = 1'b0;
                    end
                endcase
            end
            6'b101101: begin
                srd    = 2'b01;
                soh_op = 3'b001;
                alu_op = 4'b0000;
                rf_le  = 1'b1;
            end
            6'b100101: begin
                srd    = 2'b01;
                soh_op = 3'b001;
                alu_op = 4'b0010;
                rf_le  = 1'b1;
            end
            6'b100000: begin
                b      = 1'b1;
                alu_op = 4'b0010;
                id_sr  = 2'b01;
            end
            6'b111010: begin
                srd   = 2'b10;
                l     = 1'b1;
                rf_le = 1'b1;
                ub    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign id_ctrl = {srd, psw_le_re, b, soh_op, alu_op, ram_ctrl, l, rf_le, id_sr, ub};

    assign accept  = id_valid && !stall && !flush;
    assign ex_load = accept && (legal || !ILLEGAL_TRAP);

    // Every stage advances each edge; a rejected ID slot becomes a bubble in EX.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_ctrl   <= '0;
            mem_ctrl  <= '0;
            wb_ctrl   <= '0;
            ex_valid  <= 1'b0;
            mem_valid <= 1'b0;
            wb_valid  <= 1'b0;
            illegal   <= 1'b0;
            retired   <= '0;
        end else begin
            ex_ctrl   <= ex_load ? id_ctrl : 21'h0;
            ex_valid  <= ex_load;
            mem_ctrl  <= ex_ctrl;
            mem_valid <= ex_valid;
            wb_ctrl   <= mem_ctrl;
            wb_valid  <= mem_valid;
            if (ILLEGAL_TRAP && accept && !legal)
                illegal <= 1'b1;
            if (wb_valid)
                retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// Scoreboard bench: two instances (trap on / trap off, 4-bit counter) share stimulus
// and are compared every cycle against a reference pipeline model.
module tb_cu_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        id_valid;
    logic        stall;
    logic        flush;

    logic [20:0] id_ctrl_t, ex_ctrl_t, mem_ctrl_t, wb_ctrl_t;
    logic        ex_valid_t, mem_valid_t, wb_valid_t, illegal_t;
    logic [3:0]  retired_t;
    logic [20:0] id_ctrl_n, ex_ctrl_n, mem_ctrl_n, wb_ctrl_n;
    logic        ex_valid_n, mem_valid_n, wb_valid_n, illegal_n;
    logic [3:0]  retired_n;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic        rst;
        logic [20:0] ctrl_t;
        logic        v_t;
        logic [20:0] ctrl_n;
        logic        v_n;
        logic        set_ill;
    } item_t;

    item_t exp_q[$];

    logic [20:0] m_ctrl_t [3];
    logic        m_v_t    [3];
    logic [20:0] m_ctrl_n [3];
    logic        m_v_n    [3];
    logic [3:0]  m_ret_t, m_ret_n;
    logic        m_ill;

    cu_pipe_ctrl #(.CNT_W(4), .ILLEGAL_TRAP(1'b1)) dut_t (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .id_valid(id_valid),
        .stall(stall), .flush(flush), .id_ctrl(id_ctrl_t), .ex_ctrl(ex_ctrl_t),
        .mem_ctrl(mem_ctrl_t), .wb_ctrl(wb_ctrl_t), .ex_valid(ex_valid_t),
        .mem_valid(mem_valid_t), .wb_valid(wb_valid_t), .illegal(illegal_t),
        .retired(retired_t)
    );

    cu_pipe_ctrl #(.CNT_W(4), .ILLEGAL_TRAP(1'b0)) dut_n (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .id_valid(id_valid),
        .stall(stall), .flush(flush), .id_ctrl(id_ctrl_n), .ex_ctrl(ex_ctrl_n),
        .mem_ctrl(mem_ctrl_n), .wb_ctrl(wb_ctrl_n), .ex_valid(ex_valid_n),
        .mem_valid(mem_valid_n), .wb_valid(wb_valid_n), .illegal(illegal_n),
        .retired(retired_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode: {legal, control word} straight from the decode table.
    function automatic logic [21:0] ref_decode(input logic [31:0] ins);
        case (ins[31:26])
            6'b000000: return {1'b1, 21'h000000};
            6'b000010: begin
                case (ins[11:6])
                    6'b011000: return {1'b1, 21'h000008};
                    6'b011100: return {1'b1, 21'h000208};
                    6'b010000: return {1'b1, 21'h000408};
                    6'b001001: return {1'b1, 21'h000C08};
                    default:   return {1'b0, 21'h000000};
                endcase
            end
            6'b101101: return {1'b1, 21'h082008};
            6'b100101: return {1'b1, 21'h082408};
            6'b100000: return {1'b1, 21'h010402};
            6'b111010: return {1'b1, 21'h100019};
            default:   return {1'b0, 21'h000000};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("ex_ctrl_t",  32'(ex_ctrl_t),  32'(m_ctrl_t[0]));
        checkOutput("ex_valid_t", 32'(ex_valid_t), 32'(m_v_t[0]));
        checkOutput("mem_ctrl_t", 32'(mem_ctrl_t), 32'(m_ctrl_t[1]));
        checkOutput("mem_valid_t",32'(mem_valid_t),32'(m_v_t[1]));
        checkOutput("wb_ctrl_t",  32'(wb_ctrl_t),  32'(m_ctrl_t[2]));
        checkOutput("wb_valid_t", 32'(wb_valid_t), 32'(m_v_t[2]));
        checkOutput("retired_t",  32'(retired_t),  32'(m_ret_t));
        checkOutput("illegal_t",  32'(illegal_t),  32'(m_ill));
        checkOutput("ex_ctrl_n",  32'(ex_ctrl_n),  32'(m_ctrl_n[0]));
        checkOutput("ex_valid_n", 32'(ex_valid_n), 32'(m_v_n[0]));
        checkOutput("wb_ctrl_n",  32'(wb_ctrl_n),  32'(m_ctrl_n[2]));
        checkOutput("wb_valid_n", 32'(wb_valid_n), 32'(m_v_n[2]));
        checkOutput("retired_n",  32'(retired_n),  32'(m_ret_n));
        checkOutput("illegal_n",  32'(illegal_n),  32'(1'b0));
    endtask

    // Drive one cycle of ID inputs, push the expected EX entry, then retire it after the edge.
    task automatic applyStimulus(input logic rst, input logic [31:0] ins, input logic idv,
                                 input logic stl, input logic fls);
        item_t       it;
        logic [21:0] dec;
        logic        acc;
        @(negedge clk);
        rst_n       = ~rst;
        instruction = ins;
        id_valid    = idv;
        stall       = stl;
        flush       = fls;
        #1;
        dec = ref_decode(ins);
        checkOutput("id_ctrl_t", 32'(id_ctrl_t), 32'(dec[20:0]));
        checkOutput("id_ctrl_n", 32'(id_ctrl_n), 32'(dec[20:0]));
        acc        = idv && !stl && !fls;
        it.rst     = rst;
        it.v_t     = acc && dec[21];
        it.ctrl_t  = it.v_t ? dec[20:0] : 21'h0;
        it.v_n     = acc;
        it.ctrl_n  = acc ? dec[20:0] : 21'h0;
        it.set_ill = acc && !dec[21];
        exp_q.push_back(it);

        @(posedge clk);
        #1;
        it = exp_q.pop_front();
        if (it.rst) begin
            for (int i = 0; i < 3; i++) begin
                m_ctrl_t[i] = '0; m_v_t[i] = 1'b0;
                m_ctrl_n[i] = '0; m_v_n[i] = 1'b0;
            end
            m_ret_t = '0;
            m_ret_n = '0;
            m_ill   = 1'b0;
        end else begin
            m_ret_t = m_ret_t + 4'(m_v_t[2]);
            m_ret_n = m_ret_n + 4'(m_v_n[2]);
            for (int i = 2; i > 0; i--) begin
                m_ctrl_t[i] = m_ctrl_t[i-1]; m_v_t[i] = m_v_t[i-1];
                m_ctrl_n[i] = m_ctrl_n[i-1]; m_v_n[i] = m_v_n[i-1];
            end
            m_ctrl_t[0] = it.ctrl_t; m_v_t[0] = it.v_t;
            m_ctrl_n[0] = it.ctrl_n; m_v_n[0] = it.v_n;
            m_ill = m_ill | it.set_ill;
        end
        compareAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [31:0] ADD  = 32'h08000600;
    localparam logic [31:0] SUB  = 32'h08000400;
    localparam logic [31:0] ILL  = 32'h08000000;

    logic [31:0] b2b [7] = '{32'h08000700, 32'h08000400, 32'h08000240, 32'hB4000000,
                             32'h94000000, 32'h80000000, 32'hE8000000};

    initial begin
        rst_n = 1'b0; instruction = '0; id_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_ctrl_t[i] = '0; m_v_t[i] = 1'b0; m_ctrl_n[i] = '0; m_v_n[i] = 1'b0;
        end
        m_ret_t = '0; m_ret_n = '0; m_ill = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, ADD, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD, 1'b1, 1'b0, 1'b0);
        idle(4);

        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        foreach (b2b[i]) applyStimulus(1'b0, b2b[i], 1'b1, 1'b0, 1'b0);
        idle(4);

        applyStimulus(1'b0, ADD, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, SUB, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, SUB, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, SUB, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, SUB, 1'b1, 1'b0, 1'b0);
        idle(4);

        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ILL, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'hFC000000, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, ILL, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'hFC000000, 1'b1, 1'b0, 1'b0);
        idle(4);
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        idle(4);

        applyStimulus(1'b0, ADD, 1'b0, 1'b0, 1'b0);
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule
